// File: rtl/plab5_mcore_mem_net_resp_queued_pkg.sv
// Shared field definitions for the memory-response-to-network adapter.
//
// Memory response control half layout (MSB..LSB): {type, opaque, len}.
//   type   : 3 bits
//   opaque : mo bits
//   len    : clog2(md/8) bits
// Network control layout (MSB..LSB): {dest, src, opaque, payload_control}.
//   dest, src : ns bits each
//   opaque    : no bits (carries the rolling tag)
//   payload   : the memory response control half, unchanged
//
// The helper functions stand in for the field-width macros of the shared
// message headers, so port widths can be derived from module parameters.
package plab5_mcore_mem_net_resp_queued_pkg;

  localparam int unsigned MEM_RESP_TYPE_NBITS = 3;

  typedef enum logic [MEM_RESP_TYPE_NBITS-1:0] {
    MEM_RESP_READ  = 3'd0,
    MEM_RESP_WRITE = 3'd1,
    MEM_RESP_INIT  = 3'd2,
    MEM_RESP_AMO   = 3'd3
  } mem_resp_type_e;

  // Width of the byte-length field for a given data width.
  function automatic int unsigned mem_resp_len_nbits(input int unsigned md);
    return $clog2(md / 8);
  endfunction

  // Control half of a memory response: everything except the data field.
  function automatic int unsigned mem_resp_ctrl_nbits(input int unsigned mo,
                                                      input int unsigned md);
    return MEM_RESP_TYPE_NBITS + mo + mem_resp_len_nbits(md);
  endfunction

  // Network control: dest + src + opaque + payload control.
  function automatic int unsigned net_ctrl_nbits(input int unsigned pc,
                                                 input int unsigned no,
                                                 input int unsigned ns);
    return 2 * ns + no + pc;
  endfunction

  // Pointer width that stays legal for a single-entry queue.
  function automatic int unsigned ptr_nbits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_net_resp_queue.sv
// Parametrised FIFO holding {domain, control, data} per entry.
//
// Control words are kept in one array (low-security), data words in a
// separate per-entry array whose security domain is the stored domain bit.
// The head entry is presented directly from storage; when the queue is
// empty the outputs are forced to zero so no stale data or domain leaks.
//
// Build option: PLAB5_MCORE_MEM_NET_RESP_SCRUB_EN -- when defined, the
// entry freed by a dequeue has its data and domain cleared on that edge.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   enq_val/enq_rdy              enqueue handshake
//   enq_domain/control/data      entry being written
//   deq_val/deq_rdy              dequeue handshake
//   deq_domain/control/data      head entry (zero when empty)
//   occupancy                    number of entries held
module plab5_mcore_mem_net_resp_queue
  import plab5_mcore_mem_net_resp_queued_pkg::*;
#(
  parameter int unsigned p_num_entries = 2,
  parameter int unsigned p_ctrl_nbits  = 23,
  parameter int unsigned p_data_nbits  = 32
)(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enq_val,
  output logic                             enq_rdy,
  input  logic                             enq_domain,
  input  logic [p_ctrl_nbits-1:0]          enq_control,
  input  logic [p_data_nbits-1:0]          enq_data,
  output logic                             deq_val,
  input  logic                             deq_rdy,
  output logic                             deq_domain,
  output logic [p_ctrl_nbits-1:0]          deq_control,
  output logic [p_data_nbits-1:0]          deq_data,
  output logic [$clog2(p_num_entries):0]   occupancy
);

  localparam int unsigned PW = ptr_nbits(p_num_entries);
  localparam int unsigned OW = $clog2(p_num_entries) + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(p_num_entries - 1);
  localparam logic [OW-1:0] FULL_CNT = OW'(p_num_entries);

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr_nxt;
  logic [PW-1:0]           rd_ptr_nxt;
  logic [OW-1:0]           count;
  logic                    enq_fire;
  logic                    deq_fire;

  logic                    dom_q  [p_num_entries];
  logic [p_ctrl_nbits-1:0] ctrl_q [p_num_entries];
  logic [p_data_nbits-1:0] data_q [p_num_entries];

  // A full queue still accepts when the head leaves on the same edge.
  assign deq_val  = (count != '0);
  assign enq_rdy  = (count < FULL_CNT) || deq_rdy;
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  // Explicit wrap keeps non-power-of-two and single-entry depths correct.
  assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr_nxt;
      if (deq_fire) rd_ptr <= rd_ptr_nxt;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: empty entries are never presented at the output.
  // When full with enq and deq together, wr_ptr == rd_ptr; the enqueue
  // write comes last so the new entry wins over the scrub.
  always_ff @(posedge clk) begin
`ifdef PLAB5_MCORE_MEM_NET_RESP_SCRUB_EN
    if (deq_fire) begin
      dom_q[rd_ptr]  <= 1'b0;
      data_q[rd_ptr] <= '0;
    end
`endif
    if (enq_fire) begin
      dom_q[wr_ptr]  <= enq_domain;
      ctrl_q[wr_ptr] <= enq_control;
      data_q[wr_ptr] <= enq_data;
    end
  end

  assign deq_domain  = deq_val ? dom_q[rd_ptr]  : 1'b0;
  assign deq_control = deq_val ? ctrl_q[rd_ptr] : '0;
  assign deq_data    = deq_val ? data_q[rd_ptr] : '0;
  assign occupancy   = count;

endmodule

// File: rtl/plab5_mcore_mem_net_resp_queued.sv
// Buffered memory-response-to-network adapter for one bank response port.
//
// Each accepted memory response is re-packed into a network message:
//   dest   = top ns bits of the memory opaque field
//   src    = p_net_src (this bank's id)
//   opaque = rolling tag, +1 per accepted response, wraps mod 2^no
//   payload control = {type, opaque, len} unchanged, data unchanged
// and queued in a p_num_entries-deep FIFO. Outputs come only from the
// stored head entry, so there is no combinational in->out data path.
//
// Build option: PLAB5_MCORE_MEM_NET_RESP_SCRUB_EN (see queue sub-module);
// interface and timing are identical with or without it.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   in_val/in_rdy      memory response handshake
//   in_domain          security domain of the response
//   in_msg_control     {type, opaque, len}
//   in_msg_data        response data
//   out_val/out_rdy    network message handshake
//   out_domain         domain of the head entry
//   out_msg_control    {dest, src, opaque, payload control}
//   out_msg_data       payload data
//   occupancy          entries held
module plab5_mcore_mem_net_resp_queued
  import plab5_mcore_mem_net_resp_queued_pkg::*;
#(
  parameter int unsigned p_net_src           = 0,
  parameter int unsigned p_num_ports         = 4,
  parameter int unsigned p_num_entries       = 2,
  parameter int unsigned p_mem_opaque_nbits  = 8,
  parameter int unsigned p_mem_data_nbits    = 32,
  parameter int unsigned p_net_opaque_nbits  = 4,
  parameter int unsigned p_net_srcdest_nbits = 3
)(
  input  logic clk,
  input  logic reset_n,

  input  logic in_val,
  output logic in_rdy,
  input  logic in_domain,
  input  logic [mem_resp_ctrl_nbits(p_mem_opaque_nbits, p_mem_data_nbits)-1:0] in_msg_control,
  input  logic [p_mem_data_nbits-1:0] in_msg_data,

  output logic out_val,
  input  logic out_rdy,
  output logic out_domain,
  output logic [net_ctrl_nbits(mem_resp_ctrl_nbits(p_mem_opaque_nbits, p_mem_data_nbits),
                               p_net_opaque_nbits, p_net_srcdest_nbits)-1:0] out_msg_control,
  output logic [p_mem_data_nbits-1:0] out_msg_data,
  output logic [$clog2(p_num_entries):0] occupancy
);

  localparam int unsigned MO = p_mem_opaque_nbits;
  localparam int unsigned MD = p_mem_data_nbits;
  localparam int unsigned NO = p_net_opaque_nbits;
  localparam int unsigned NS = p_net_srcdest_nbits;
  localparam int unsigned LB = mem_resp_len_nbits(MD);
  localparam int unsigned RC = mem_resp_ctrl_nbits(MO, MD);
  localparam int unsigned NC = net_ctrl_nbits(RC, NO, NS);

  localparam logic [NS-1:0] SRC_ID = NS'(p_net_src);

  // Configuration sanity: every port must be addressable and the dest
  // slice must fit inside the memory opaque field.
  if (p_num_ports > (1 << NS)) begin : g_bad_ports
    $error("p_num_ports does not fit in p_net_srcdest_nbits");
  end
  if (NS > MO) begin : g_bad_srcdest
    $error("p_net_srcdest_nbits must not exceed p_mem_opaque_nbits");
  end

  logic [NO-1:0] tag;
  logic [NS-1:0] dest;
  logic [NC-1:0] pack_control;
  logic          enq_fire;

  // Opaque sits just above the len field; dest is its top NS bits.
  assign dest         = in_msg_control[LB+MO-1 -: NS];
  assign pack_control = {dest, SRC_ID, tag, in_msg_control};
  assign enq_fire     = in_val && in_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag <= '0;
    end else if (enq_fire) begin
      tag <= tag + 1'b1;
    end
  end

  plab5_mcore_mem_net_resp_queue #(
    .p_num_entries (p_num_entries),
    .p_ctrl_nbits  (NC),
    .p_data_nbits  (MD)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .enq_val     (in_val),
    .enq_rdy     (in_rdy),
    .enq_domain  (in_domain),
    .enq_control (pack_control),
    .enq_data    (in_msg_data),
    .deq_val     (out_val),
    .deq_rdy     (out_rdy),
    .deq_domain  (out_domain),
    .deq_control (out_msg_control),
    .deq_data    (out_msg_data),
    .occupancy   (occupancy)
  );

endmodule

// File: tb/tb_plab5_mcore_mem_net_resp_queued.sv
`timescale 1ns/1ps
module tb_plab5_mcore_mem_net_resp_queued;

  localparam int N   = 2;
  localparam int MO  = 8;
  localparam int MD  = 32;
  localparam int NO  = 4;
  localparam int NS  = 3;
  localparam int SRC = 5;
  localparam int RC  = 13;            // 3 type + 8 opaque + 2 len
  localparam int NC  = 2*NS + NO + RC; // 23

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_val;
  logic          in_rdy;
  logic          in_domain;
  logic [RC-1:0] in_msg_control;
  logic [MD-1:0] in_msg_data;
  logic          out_val;
  logic          out_rdy;
  logic          out_domain;
  logic [NC-1:0] out_msg_control;
  logic [MD-1:0] out_msg_data;
  logic [$clog2(N):0] occupancy;

  always #5 clk = ~clk;

  plab5_mcore_mem_net_resp_queued #(
    .p_net_src           (SRC),
    .p_num_ports         (4),
    .p_num_entries       (N),
    .p_mem_opaque_nbits  (MO),
    .p_mem_data_nbits    (MD),
    .p_net_opaque_nbits  (NO),
    .p_net_srcdest_nbits (NS)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .in_domain       (in_domain),
    .in_msg_control  (in_msg_control),
    .in_msg_data     (in_msg_data),
    .out_val         (out_val),
    .out_rdy         (out_rdy),
    .out_domain      (out_domain),
    .out_msg_control (out_msg_control),
    .out_msg_data    (out_msg_data),
    .occupancy       (occupancy)
  );

  typedef struct packed {
    logic          dom;
    logic [NC-1:0] ctrl;
    logic [MD-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   tag_m = 0;          // reference tag counter
  int   last_out_tag = -1;  // tag seen on the DUT at the most recent dequeue
  logic model_rdy = 1'b1;   // reference ready for the current cycle

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [RC-1:0] mk_ctrl(input logic [2:0] typ, input logic [7:0] op,
                                            input logic [1:0] len);
    return {typ, op, len};
  endfunction

  // Reference packing: fields computed from the message rules directly.
  function automatic exp_t expect_msg(input logic d, input logic [RC-1:0] c,
                                      input logic [MD-1:0] dt, input int tg);
    exp_t e;
    int op;
    logic [NS-1:0] dst;
    logic [NS-1:0] src;
    logic [NO-1:0] t;
    op  = int'(c) / 4 % 256;      // drop 2-bit len, keep 8-bit opaque
    dst = NS'(op / (1 << (MO - NS)));
    src = NS'(SRC);
    t   = NO'(tg);
    e.dom  = d;
    e.ctrl = {dst, src, t, c};
    e.data = dt;
    return e;
  endfunction

  // Monitor: one cycle after inputs settle, compare against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (reset_n === 1'b1) begin
      model_rdy = (exp_q.size() < N) || out_rdy;
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("out_val", 64'(out_val), 64'(exp_q.size() != 0));
      chk("in_rdy", 64'(in_rdy), 64'(model_rdy));
      if (exp_q.size() == 0) begin
        chk("empty_domain", 64'(out_domain), 64'd0);
        chk("empty_data", 64'(out_msg_data), 64'd0);
      end else begin
        chk("head_domain", 64'(out_domain), 64'(exp_q[0].dom));
        chk("head_control", 64'(out_msg_control), 64'(exp_q[0].ctrl));
        chk("head_data", 64'(out_msg_data), 64'(exp_q[0].data));
        if (out_rdy) begin
          last_out_tag = int'(out_msg_control[RC +: NO]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One stimulus cycle: drive at negedge, push expectation if model accepts.
  task automatic cycle(input logic v, input logic d, input logic [RC-1:0] c,
                       input logic [MD-1:0] dt, input logic ordy, output logic fired);
    @(negedge clk);
    in_val = v; in_domain = d; in_msg_control = c; in_msg_data = dt; out_rdy = ordy;
    #2;
    fired = v && model_rdy;
    if (fired) begin
      exp_q.push_back(expect_msg(d, c, dt, tag_m));
      tag_m = (tag_m + 1) % (1 << NO);
    end
  endtask

  task automatic idle(input logic ordy);
    logic f;
    cycle(1'b0, 1'b0, '0, '0, ordy, f);
  endtask

  task automatic rnd_cycle(input logic v, input logic ordy);
    logic f;
    cycle(v, 1'($urandom), RC'($urandom), $urandom, ordy, f);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    #1;
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_domain", 64'(out_domain), 64'd0);
    chk("rst_out_data", 64'(out_msg_data), 64'd0);
    chk("rst_out_control", 64'(out_msg_control), 64'd0);
    exp_q.delete();
    tag_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic f;
  logic [MD-1:0] scrub_exp;
  logic          scrub_dom_exp;

  initial begin
    reset_n = 1'b0; in_val = 1'b0; in_domain = 1'b0;
    in_msg_control = '0; in_msg_data = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset();

    // Single response: opaque 0x40 -> dest 2, tag 0, visible next cycle.
    cycle(1'b1, 1'b0, mk_ctrl(3'd0, 8'h40, 2'd0), 32'hDEADBEEF, 1'b1, f);
    idle(1'b1);
    chk("t1_dest", 64'(out_msg_control[NC-1 -: NS]), 64'd2);
    chk("t1_src", 64'(out_msg_control[NC-NS-1 -: NS]), 64'(SRC));
    chk("t1_tag", 64'(out_msg_control[RC +: NO]), 64'd0);
    chk("t1_data", 64'(out_msg_data), 64'hDEADBEEF);
    idle(1'b1);

    // 17 back-to-back: tags 0..15 then wrap to 0, never stalled.
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      rnd_cycle(1'b1, 1'b1);
      chk("t2_in_rdy", 64'(in_rdy), 64'd1);
    end
    repeat (3) idle(1'b1);
    chk("t2_wrap_tag", 64'(last_out_tag), 64'd0);

    // Fill with out_rdy low, domain 1 then 0; then release in order.
    apply_reset();
    cycle(1'b1, 1'b1, RC'($urandom), $urandom, 1'b0, f);
    cycle(1'b1, 1'b0, RC'($urandom), $urandom, 1'b0, f);
    cycle(1'b1, 1'b1, RC'($urandom), $urandom, 1'b0, f);
    chk("t3_in_rdy_full", 64'(in_rdy), 64'd0);
    chk("t3_occupancy", 64'(occupancy), 64'd2);
    idle(1'b0);
    idle(1'b1);
    chk("t3_first_domain", 64'(out_domain), 64'd1);
    idle(1'b1);
    chk("t3_second_domain", 64'(out_domain), 64'd0);
    idle(1'b1);

    // Full queue, enqueue and dequeue on the same edge.
    apply_reset();
    rnd_cycle(1'b1, 1'b0);
    rnd_cycle(1'b1, 1'b0);
    rnd_cycle(1'b1, 1'b1);
    chk("t4_in_rdy_full_deq", 64'(in_rdy), 64'd1);
    idle(1'b0);
    chk("t4_occupancy", 64'(occupancy), 64'd2);
    repeat (3) idle(1'b1);

    // Reset with two entries queued; first message afterwards has tag 0.
    apply_reset();
    rnd_cycle(1'b1, 1'b0);
    rnd_cycle(1'b1, 1'b0);
    rnd_cycle(1'b1, 1'b0);
    apply_reset();
    rnd_cycle(1'b1, 1'b1);
    idle(1'b1);
    chk("t5_post_reset_tag", 64'(out_msg_control[RC +: NO]), 64'd0);
    idle(1'b1);

    // Freed slot contents after a dequeue.
    apply_reset();
    cycle(1'b1, 1'b1, RC'($urandom), 32'hA5A5A5A5, 1'b0, f);
    idle(1'b1);
    idle(1'b0);
`ifdef PLAB5_MCORE_MEM_NET_RESP_SCRUB_EN
    scrub_exp = '0;
    scrub_dom_exp = 1'b0;
`else
    scrub_exp = 32'hA5A5A5A5;
    scrub_dom_exp = 1'b1;
`endif
    chk("t6_slot_data", 64'(dut.u_queue.data_q[0]), 64'(scrub_exp));
    chk("t6_slot_domain", 64'(dut.u_queue.dom_q[0]), 64'(scrub_dom_exp));

    // Randomized traffic with occasional resets.
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      rnd_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    repeat (N + 3) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
